// File: rtl/fetch_mem_arbiter_pkg.sv
// fetch_mem_arbiter_pkg
//   Shared constants and types for the fetch/data SRAM arbiter.
//   DEF_WORD_LEN     : address/data width default
//   DEF_STARVE_LIMIT : data grants in a row (with fetch waiting) before fetch wins
//   arb_state_e      : 3-bit arbiter state encoding
package fetch_mem_arbiter_pkg;

    localparam int DEF_WORD_LEN     = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } arb_state_e;

    // Bits needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// fetch_mem_arbiter_if
//   Bundles the fetch requester, data requester and SRAM handshake signals.
//   slave  : arbiter view (takes requests and SRAM responses, drives grants)
//   master : environment view (requesters plus SRAM model)
//   Fetch : ifReq, ifAddr -> ifInstr, ifReady, freezeIF
//   Data  : dRead, dWrite, dAddr, dWdata -> dRdata, dReady, freezePipe
//   SRAM  : sramReq, sramWe, sramAddr, sramWdata <- sramRdata, sramAck
interface fetch_mem_arbiter_if
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN
);
    logic                ifReq;
    logic [WORD_LEN-1:0] ifAddr;
    logic [WORD_LEN-1:0] ifInstr;
    logic                ifReady;
    logic                dRead;
    logic                dWrite;
    logic [WORD_LEN-1:0] dAddr;
    logic [WORD_LEN-1:0] dWdata;
    logic [WORD_LEN-1:0] dRdata;
    logic                dReady;
    logic                freezeIF;
    logic                freezePipe;
    logic                sramReq;
    logic                sramWe;
    logic [WORD_LEN-1:0] sramAddr;
    logic [WORD_LEN-1:0] sramWdata;
    logic [WORD_LEN-1:0] sramRdata;
    logic                sramAck;

    modport slave (
        input  ifReq, ifAddr, dRead, dWrite, dAddr, dWdata, sramRdata, sramAck,
        output ifInstr, ifReady, dRdata, dReady, freezeIF, freezePipe,
               sramReq, sramWe, sramAddr, sramWdata
    );

    modport master (
        output ifReq, ifAddr, dRead, dWrite, dAddr, dWdata, sramRdata, sramAck,
        input  ifInstr, ifReady, dRdata, dReady, freezeIF, freezePipe,
               sramReq, sramWe, sramAddr, sramWdata
    );

endinterface

// File: rtl/fetch_mem_arbiter_starve_counter.sv
// fetch_mem_arbiter_starve_counter
//   Saturating up-counter tracking how many data grants fetch has waited through.
//   clk, rst : clock, async active-high reset
//   inc_i    : count one more data grant (saturates at LIMIT)
//   clr_i    : fetch was granted; restart from zero (wins over inc_i)
//   full_o   : count has reached LIMIT
module fetch_mem_arbiter_starve_counter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic full_o
);
    localparam int CW = cnt_width(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o = (cnt_q == CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !full_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
//   Shares one single-ported SRAM between instruction fetch and MEM-stage
//   loads/stores. Data wins arbitration unless fetch has been passed over
//   STARVE_LIMIT times in a row. Each access is IDLE -> BUSY -> DONE, so at
//   most one access completes every three cycles.
//   clk, rst : clock, async active-high reset
//   bus      : fetch/data requesters and SRAM handshake (slave modport)
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | no access in flight; arbitrate at the next edge
//   ST_BUSY_I | SRAM read for fetch outstanding, waiting for sramAck
//   ST_BUSY_D | SRAM load/store outstanding, waiting for sramAck
//   ST_DONE_I | ifReady pulse cycle
//   ST_DONE_D | dReady pulse cycle
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int WORD_LEN     = DEF_WORD_LEN,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    fetch_mem_arbiter_if.slave bus
);
    arb_state_e          state_q, state_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic [WORD_LEN-1:0] sram_addr_q, sram_addr_d;
    logic [WORD_LEN-1:0] sram_wdata_q, sram_wdata_d;
    logic [WORD_LEN-1:0] if_instr_q, if_instr_d;
    logic [WORD_LEN-1:0] d_rdata_q, d_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;

    logic d_req;
    logic starve_full;
    logic grant_d;
    logic grant_i;

    assign d_req   = bus.dRead | bus.dWrite;
    // Fetch only overrides a pending data request once it has been starved.
    assign grant_d = (state_q == ST_IDLE) && d_req && !(bus.ifReq && starve_full);
    assign grant_i = (state_q == ST_IDLE) && bus.ifReq && !grant_d;

    fetch_mem_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (grant_d & bus.ifReq),
        .clr_i  (grant_i),
        .full_o (starve_full)
    );

    always_comb begin
        state_d      = state_q;
        sram_req_d   = sram_req_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_instr_d   = if_instr_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d      = ST_BUSY_D;
                    sram_req_d   = 1'b1;
                    sram_we_d    = bus.dWrite;   // read+write together counts as a write
                    sram_addr_d  = bus.dAddr;
                    sram_wdata_d = bus.dWdata;
                end else if (grant_i) begin
                    state_d     = ST_BUSY_I;
                    sram_req_d  = 1'b1;
                    sram_we_d   = 1'b0;
                    sram_addr_d = bus.ifAddr;
                end
            end
            ST_BUSY_I: begin
                if (bus.sramAck) begin
                    state_d    = ST_DONE_I;
                    sram_req_d = 1'b0;
                    if_instr_d = bus.sramRdata;
                    if_ready_d = 1'b1;
                end
            end
            ST_BUSY_D: begin
                if (bus.sramAck) begin
                    state_d    = ST_DONE_D;
                    sram_req_d = 1'b0;
                    if (!sram_we_q) begin
                        d_rdata_d = bus.sramRdata;
                    end
                    d_ready_d = 1'b1;
                end
            end
            ST_DONE_I, ST_DONE_D: begin
                // Requesters update at the DONE edge, so always take an IDLE bubble.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_instr_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_instr_q   <= if_instr_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign bus.sramReq    = sram_req_q;
    assign bus.sramWe     = sram_we_q;
    assign bus.sramAddr   = sram_addr_q;
    assign bus.sramWdata  = sram_wdata_q;
    assign bus.ifInstr    = if_instr_q;
    assign bus.ifReady    = if_ready_q;
    assign bus.dRdata     = d_rdata_q;
    assign bus.dReady     = d_ready_q;
    assign bus.freezeIF   = bus.ifReq & ~if_ready_q;
    assign bus.freezePipe = d_req & ~d_ready_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
`timescale 1ns/1ps
module tb_fetch_mem_arbiter;
    import fetch_mem_arbiter_pkg::*;

    localparam int W     = DEF_WORD_LEN;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_mem_arbiter_if #(.WORD_LEN(W)) bus();

    fetch_mem_arbiter #(.WORD_LEN(W), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          store;
        logic [31:0] val;
    } dexp_t;

    logic [31:0] sram_mem [0:31];
    logic [31:0] ref_mem  [0:31];
    logic [31:0] if_q[$];
    dexp_t       d_q[$];

    bit sram_auto   = 1'b1;
    int fixed_delay = 0;     // < 0 selects a random 0..3 wait

    // transaction-level model state
    int          phase = 0;  // 0 waiting for grant, 1 access open, 2 completion cycle
    bit          cur_is_d;
    logic [31:0] exp_addr, exp_wdata;
    bit          exp_we;
    int          starve = 0;
    logic [31:0] last_load = '0;
    bit          exp_ir, exp_dr, i_req, dd_req;
    bit          log_en = 1'b0;
    bit          grant_log[$];

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_0000 ^ (32'(i) * 32'h0101_0103);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_fetch(input logic [31:0] a);
        bus.ifReq  = 1'b1;
        bus.ifAddr = a;
        if_q.push_back(ref_mem[a[6:2]]);
    endtask

    task automatic issue_data(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        bus.dRead  = rd;
        bus.dWrite = wr;
        bus.dAddr  = a;
        bus.dWdata = wd;
        if (wr) begin
            d_q.push_back('{store: 1'b1, val: 32'h0});
            ref_mem[a[6:2]] = wd;
        end else begin
            d_q.push_back('{store: 1'b0, val: ref_mem[a[6:2]]});
        end
    endtask

    task automatic wait_ready(input bit is_d, input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((is_d && bus.dReady) || (!is_d && bus.ifReady)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: no ready pulse within 200 cycles", name);
    endtask

    // SRAM model: acks each access after a programmable wait
    initial begin
        int wcnt;
        bit sent;
        wcnt = 0;
        sent = 1'b0;
        bus.sramAck   = 1'b0;
        bus.sramRdata = '0;
        forever begin
            @(negedge clk);
            if (sram_auto) begin
                bus.sramAck = 1'b0;
                if (!bus.sramReq) begin
                    sent = 1'b0;
                    wcnt = (fixed_delay < 0) ? int'($urandom_range(3, 0)) : fixed_delay;
                end else if (!sent) begin
                    if (wcnt == 0) begin
                        bus.sramAck   = 1'b1;
                        bus.sramRdata = sram_mem[bus.sramAddr[6:2]];
                        if (bus.sramWe) sram_mem[bus.sramAddr[6:2]] = bus.sramWdata;
                        sent = 1'b1;
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard: sampled 1 ns after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            exp_ir = 1'b0;
            exp_dr = 1'b0;
            if (rst) begin
                phase     = 0;
                starve    = 0;
                last_load = '0;
                if_q.delete();
                d_q.delete();
                chk1("rst_sramReq", bus.sramReq, 1'b0);
                chk1("rst_ifReady", bus.ifReady, 1'b0);
                chk1("rst_dReady", bus.dReady, 1'b0);
            end else begin
                case (phase)
                    0: begin
                        i_req  = bus.ifReq;
                        dd_req = bus.dRead | bus.dWrite;
                        if (dd_req && !(i_req && starve == LIMIT)) begin
                            cur_is_d  = 1'b1;
                            phase     = 1;
                            exp_addr  = bus.dAddr;
                            exp_we    = bus.dWrite;
                            exp_wdata = bus.dWdata;
                            if (i_req && starve < LIMIT) starve++;
                        end else if (i_req) begin
                            cur_is_d = 1'b0;
                            phase    = 1;
                            exp_addr = bus.ifAddr;
                            exp_we   = 1'b0;
                            starve   = 0;
                        end
                        if (phase == 1 && log_en) grant_log.push_back(cur_is_d);
                    end
                    1: begin
                        if (bus.sramAck) begin
                            phase = 2;
                            if (cur_is_d) exp_dr = 1'b1;
                            else          exp_ir = 1'b1;
                        end
                    end
                    default: phase = 0;
                endcase

                chk1("sramReq", bus.sramReq, phase == 1);
                if (phase == 1) begin
                    chk32("sramAddr", bus.sramAddr, exp_addr);
                    chk1("sramWe", bus.sramWe, exp_we);
                    if (exp_we) chk32("sramWdata", bus.sramWdata, exp_wdata);
                end
                chk1("ifReady", bus.ifReady, exp_ir);
                chk1("dReady", bus.dReady, exp_dr);
                if (exp_ir) begin
                    if (if_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ifInstr_sb: ready with no fetch outstanding at %0t", $time);
                    end else begin
                        chk32("ifInstr", bus.ifInstr, if_q.pop_front());
                    end
                end
                if (exp_dr) begin
                    if (d_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dRdata_sb: ready with no data access outstanding at %0t", $time);
                    end else begin
                        dexp_t e;
                        e = d_q.pop_front();
                        if (!e.store) last_load = e.val;
                        chk32("dRdata", bus.dRdata, last_load);
                    end
                end
                chk1("freezeIF", bus.freezeIF, bus.ifReq & ~exp_ir);
                chk1("freezePipe", bus.freezePipe, (bus.dRead | bus.dWrite) & ~exp_dr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_log [10];
        int held;
        int dp;
        bit seen;

        for (int i = 0; i < 32; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        sram_mem[4] = 32'h8C22_0004;
        ref_mem[4]  = 32'h8C22_0004;

        bus.ifReq  = 1'b0;
        bus.ifAddr = '0;
        bus.dRead  = 1'b0;
        bus.dWrite = 1'b0;
        bus.dAddr  = '0;
        bus.dWdata = '0;

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1 ("reset_sramReq", bus.sramReq, 1'b0);
        chk1 ("reset_sramWe", bus.sramWe, 1'b0);
        chk32("reset_sramAddr", bus.sramAddr, 32'h0);
        chk32("reset_sramWdata", bus.sramWdata, 32'h0);
        chk32("reset_ifInstr", bus.ifInstr, 32'h0);
        chk32("reset_dRdata", bus.dRdata, 32'h0);
        chk1 ("reset_ifReady", bus.ifReady, 1'b0);
        chk1 ("reset_dReady", bus.dReady, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // lone fetch, ack one cycle after request
        issue_fetch(32'h10);
        #1;
        chk1("t1_freezeIF_c1", bus.freezeIF, 1'b1);
        chk1("t1_sramReq_c1", bus.sramReq, 1'b0);
        @(negedge clk);
        chk1 ("t1_sramReq_c2", bus.sramReq, 1'b1);
        chk32("t1_sramAddr", bus.sramAddr, 32'h10);
        chk1 ("t1_sramWe", bus.sramWe, 1'b0);
        chk1 ("t1_freezeIF_c2", bus.freezeIF, 1'b1);
        @(negedge clk);
        chk1 ("t1_ifReady_c3", bus.ifReady, 1'b1);
        chk32("t1_ifInstr", bus.ifInstr, 32'h8C22_0004);
        chk1 ("t1_sramReq_c3", bus.sramReq, 1'b0);
        chk1 ("t1_freezeIF_c3", bus.freezeIF, 1'b0);
        bus.ifReq = 1'b0;
        @(negedge clk);
        chk1("t1_ifReady_c4", bus.ifReady, 1'b0);

        // simultaneous fetch and load: data first
        issue_fetch(32'h20);
        issue_data(1'b1, 1'b0, 32'h40, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (n == 0) chk32("t2_first_grant_addr", bus.sramAddr, 32'h40);
            chk1("t2_freezeIF_held", bus.freezeIF, 1'b1);
            if (bus.dReady) begin
                seen = 1'b1;
                break;
            end
        end
        chk1 ("t2_dReady_seen", seen, 1'b1);
        chk32("t2_dRdata", bus.dRdata, init_word(16));
        bus.dRead = 1'b0;
        wait_ready(1'b0, "t2_fetch");
        chk32("t2_ifInstr", bus.ifInstr, init_word(8));
        bus.ifReq = 1'b0;

        // store with 3 wait cycles
        fixed_delay = 3;
        @(negedge clk);
        issue_data(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF);
        held = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.sramReq && bus.sramWe && bus.sramWdata == 32'hDEAD_BEEF && bus.sramAddr == 32'h44)
                held++;
            if (bus.dReady) break;
        end
        chk32("t3_wdata_held_cycles", 32'(held), 32'd4);
        chk1 ("t3_dReady", bus.dReady, 1'b1);
        chk32("t3_dRdata_unchanged", bus.dRdata, init_word(16));
        bus.dWrite = 1'b0;
        dp = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.dReady) dp++;
        end
        chk32("t3_extra_dReady", 32'(dp), 32'd0);
        chk32("t3_mem_written", sram_mem[17], 32'hDEAD_BEEF);
        fixed_delay = 0;

        // starvation: fetch held, loads back-to-back
        grant_log.delete();
        log_en = 1'b1;
        issue_fetch(32'h24);
        issue_data(1'b1, 1'b0, 32'h50, 32'h0);
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_ready(1'b0, "t4_fetch");
                    if (k == 0) issue_fetch(32'h28);
                    else        bus.ifReq = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    wait_ready(1'b1, "t4_data");
                    if (k < 7) issue_data(1'b1, 1'b0, 32'h54 + 32'(4 * k), 32'h0);
                    else       bus.dRead = 1'b0;
                end
            end
        join
        log_en  = 1'b0;
        exp_log = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        chk32("t4_grant_count", 32'(grant_log.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < grant_log.size()) chk1($sformatf("t4_grant_%0d_is_data", k), grant_log[k], exp_log[k]);
        end

        // reset during a load, stale ack afterwards
        sram_auto   = 1'b0;
        bus.sramAck = 1'b0;
        @(negedge clk);
        issue_data(1'b1, 1'b0, 32'h48, 32'h0);
        @(negedge clk);
        chk1("t5_busy_sramReq", bus.sramReq, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("t5_sramReq_async_drop", bus.sramReq, 1'b0);
        chk32("t5_dRdata_cleared", bus.dRdata, 32'h0);
        bus.dRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.sramAck   = 1'b1;
        bus.sramRdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.sramAck = 1'b0;
        dp = 0;
        repeat (4) begin
            chk1("t5_idle_sramReq", bus.sramReq, 1'b0);
            if (bus.dReady || bus.ifReady) dp++;
            @(negedge clk);
        end
        chk32("t5_no_ready_pulse", 32'(dp), 32'd0);
        sram_auto = 1'b1;
        issue_fetch(32'h30);
        wait_ready(1'b0, "t5_fetch");
        chk32("t5_fetch_after_reset", bus.ifInstr, ref_mem[12]);
        bus.ifReq = 1'b0;

        // randomized mixed traffic with random SRAM wait states
        fixed_delay = -1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                    issue_fetch(32'(4 * $urandom_range(15, 0)));
                    wait_ready(1'b0, "rnd_fetch");
                    bus.ifReq = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    int op;
                    logic [31:0] a;
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                    op = int'($urandom_range(3, 0));
                    a  = 32'h40 + 32'(4 * $urandom_range(15, 0));
                    issue_data(op != 2, op >= 2, a, $urandom);
                    wait_ready(1'b1, "rnd_data");
                    bus.dRead  = 1'b0;
                    bus.dWrite = 1'b0;
                end
            end
        join

        repeat (4) @(negedge clk);
        chk32("end_fetch_queue_empty", 32'(if_q.size()), 32'd0);
        chk32("end_data_queue_empty", 32'(d_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
